// File: rtl/uart_mmio_pkg.sv
// Shared constants and types for the memory-mapped UART.
// Holds register byte offsets, CON/STAT bit positions, the TX/RX state
// encodings and the oversampling ratio used by both serial engines.
package uart_mmio_pkg;

  // Register byte offsets from BASE_ADDR
  localparam logic [4:0] OFF_TXD  = 5'h00;
  localparam logic [4:0] OFF_RXD  = 5'h04;
  localparam logic [4:0] OFF_CON  = 5'h08;
  localparam logic [4:0] OFF_STAT = 5'h0C;
  localparam logic [4:0] OFF_DIV  = 5'h10;
  localparam logic [31:0] MAP_SIZE = 32'd20;

  // CON bits
  localparam int unsigned CON_TX_EN     = 0;
  localparam int unsigned CON_RX_EN     = 1;
  localparam int unsigned CON_RX_IRQ_EN = 2;
  localparam int unsigned CON_TX_IRQ_EN = 3;
  localparam logic [3:0]  CON_RESET     = 4'b0011;

  // STAT bits
  localparam int unsigned STAT_TX_FULL   = 0;
  localparam int unsigned STAT_TX_EMPTY  = 1;
  localparam int unsigned STAT_RX_FULL   = 2;
  localparam int unsigned STAT_RX_VALID  = 3;
  localparam int unsigned STAT_RX_OVR    = 4;
  localparam int unsigned STAT_TX_OVF    = 5;
  localparam int unsigned STAT_FRAME_ERR = 6;
  localparam int unsigned STAT_TX_BUSY   = 7;
  localparam int unsigned STAT_TX_CNT    = 8;
  localparam int unsigned STAT_RX_CNT    = 16;

  // Ticks per bit time
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO used for the UART TX and RX queues.
// Ports: clk, reset (async, active-low), push/wdata, pop/rdata (head, valid
// when not empty), full, empty, count (0..DEPTH).
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty is ignored.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, programmable baud divisor and
// 16x-oversampled receiver.
// Ports: clk, reset (async, active-low); bus rd/wr/addr/wdata, rdata
// (combinational, 0 unless a mapped register is read); uart_rx serial in
// (asynchronous), uart_tx serial out (idle high); irq level interrupt.
// Registers: TXD 0x00, RXD 0x04, CON 0x08, STAT 0x0C, DIV 0x10.
module uart_mmio_fifo
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0018,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIV_RESET  = 325
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  // Bus decode; the low two address bits are ignored.
  logic [31:0] offs;
  logic        hit;
  logic [4:0]  reg_off;
  logic        wr_txd, rd_rxd, wr_con, wr_stat, wr_div;

  assign offs    = addr - BASE_ADDR;
  assign hit     = (offs < MAP_SIZE);
  assign reg_off = {offs[4:2], 2'b00};
  assign wr_txd  = wr & hit & (reg_off == OFF_TXD);
  assign rd_rxd  = rd & hit & (reg_off == OFF_RXD);
  assign wr_con  = wr & hit & (reg_off == OFF_CON);
  assign wr_stat = wr & hit & (reg_off == OFF_STAT);
  assign wr_div  = wr & hit & (reg_off == OFF_DIV);

  logic unused_wdata;
  assign unused_wdata = ^wdata;

  logic [3:0]       con_q;
  logic [DIV_W-1:0] div_q, div_eff, tick_cnt_q;
  logic             tick;
  logic             rx_ovr_q, tx_ovf_q, frame_err_q, irq_q;

  // FIFOs
  logic              tx_start, tx_full, tx_empty;
  logic [DATA_W-1:0] tx_head;
  logic [CNT_W-1:0]  tx_count;
  logic              rx_push, rx_full, rx_empty;
  logic [DATA_W-1:0] rx_head, rx_shift_q;
  logic [CNT_W-1:0]  rx_count;

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txd),
    .wdata (wdata[DATA_W-1:0]),
    .pop   (tx_start),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .wdata (rx_shift_q),
    .pop   (rd_rxd),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Oversample tick; a divisor of 0 runs at the divide-by-1 rate.
  assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
  assign tick    = (tick_cnt_q == div_eff - DIV_W'(1));

  // TX engine
  tx_state_e        tx_state_q;
  logic [TICK_W-1:0] tx_tick_q;
  logic [BIT_W-1:0] tx_bit_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic             uart_tx_q, tx_last, tx_busy;

  assign tx_last  = (tx_tick_q == LAST_TICK);
  assign tx_busy  = (tx_state_q != TxIdle);
  // Start from IDLE, or straight out of the last stop tick so frames abut.
  assign tx_start = tick & con_q[CON_TX_EN] & ~tx_empty &
                    ((tx_state_q == TxIdle) | ((tx_state_q == TxStop) & tx_last));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TxIdle;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      uart_tx_q  <= 1'b1;
    end else if (tick) begin
      unique case (tx_state_q)
        TxIdle: begin
          if (tx_start) begin
            tx_state_q <= TxStart;
            tx_tick_q  <= '0;
            tx_shift_q <= tx_head;
            uart_tx_q  <= 1'b0;
          end
        end
        TxStart: begin
          tx_tick_q <= tx_tick_q + 1'b1;
          if (tx_last) begin
            tx_state_q <= TxData;
            tx_bit_q   <= '0;
            uart_tx_q  <= tx_shift_q[0];
          end
        end
        TxData: begin
          tx_tick_q <= tx_tick_q + 1'b1;
          if (tx_last) begin
            if (tx_bit_q == LAST_BIT) begin
              tx_state_q <= TxStop;
              uart_tx_q  <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_shift_q <= tx_shift_q >> 1;
              uart_tx_q  <= tx_shift_q[1];
            end
          end
        end
        TxStop: begin
          tx_tick_q <= tx_tick_q + 1'b1;
          if (tx_last) begin
            if (tx_start) begin
              tx_state_q <= TxStart;
              tx_shift_q <= tx_head;
              uart_tx_q  <= 1'b0;
            end else begin
              tx_state_q <= TxIdle;
            end
          end
        end
      endcase
    end
  end

  assign uart_tx = uart_tx_q;

  // RX engine
  rx_state_e         rx_state_q;
  logic [TICK_W-1:0] rx_tick_q;
  logic [BIT_W-1:0]  rx_bit_q;
  logic              rx_s1_q, rx_s2_q, rx_line, rx_last, rx_stop_sample;
  logic              frame_set, rx_ovr_set, tx_ovf_set;

  assign rx_line        = rx_s2_q;
  assign rx_last        = (rx_tick_q == LAST_TICK);
  assign rx_stop_sample = tick & con_q[CON_RX_EN] & (rx_state_q == RxStop) & rx_last;
  assign rx_push        = rx_stop_sample & rx_line;
  assign frame_set      = rx_stop_sample & ~rx_line;
  // A CPU pop in the same cycle frees a slot, so that is not an overrun.
  assign rx_ovr_set     = rx_push & rx_full & ~rd_rxd;
  assign tx_ovf_set     = wr_txd & tx_full & ~tx_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RxIdle;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else if (!con_q[CON_RX_EN]) begin
      rx_state_q <= RxIdle;
    end else if (tick) begin
      unique case (rx_state_q)
        RxIdle: begin
          if (!rx_line) begin
            rx_state_q <= RxStart;
            rx_tick_q  <= '0;
          end
        end
        RxStart: begin
          rx_tick_q <= rx_tick_q + 1'b1;
          if (rx_tick_q == MID_TICK) begin
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_line ? RxIdle : RxData;
          end
        end
        RxData: begin
          rx_tick_q <= rx_tick_q + 1'b1;
          if (rx_last) begin
            rx_shift_q <= {rx_line, rx_shift_q[DATA_W-1:1]};
            if (rx_bit_q == LAST_BIT) rx_state_q <= RxStop;
            else                      rx_bit_q   <= rx_bit_q + 1'b1;
          end
        end
        RxStop: begin
          rx_tick_q <= rx_tick_q + 1'b1;
          if (rx_last) rx_state_q <= rx_line ? RxIdle : RxBreak;
        end
        RxBreak: begin
          if (rx_line) rx_state_q <= RxIdle;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Control, divisor, sticky flags and interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      con_q       <= CON_RESET;
      div_q       <= DIV_W'(DIV_RESET);
      tick_cnt_q  <= '0;
      rx_ovr_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (wr_con) con_q <= wdata[3:0];
      if (wr_div) div_q <= wdata[DIV_W-1:0];

      if (wr_div || tick) tick_cnt_q <= '0;
      else                tick_cnt_q <= tick_cnt_q + 1'b1;

      // Set takes priority over a same-cycle write-1-to-clear.
      rx_ovr_q    <= rx_ovr_set | (rx_ovr_q    & ~(wr_stat & wdata[STAT_RX_OVR]));
      tx_ovf_q    <= tx_ovf_set | (tx_ovf_q    & ~(wr_stat & wdata[STAT_TX_OVF]));
      frame_err_q <= frame_set  | (frame_err_q & ~(wr_stat & wdata[STAT_FRAME_ERR]));

      irq_q <= (con_q[CON_RX_IRQ_EN] & ~rx_empty) |
               (con_q[CON_TX_IRQ_EN] & tx_empty & ~tx_busy);
    end
  end

  assign irq = irq_q;

  // Read mux
  logic [31:0] stat;

  always_comb begin
    stat                      = '0;
    stat[STAT_TX_FULL]        = tx_full;
    stat[STAT_TX_EMPTY]       = tx_empty;
    stat[STAT_RX_FULL]        = rx_full;
    stat[STAT_RX_VALID]       = ~rx_empty;
    stat[STAT_RX_OVR]         = rx_ovr_q;
    stat[STAT_TX_OVF]         = tx_ovf_q;
    stat[STAT_FRAME_ERR]      = frame_err_q;
    stat[STAT_TX_BUSY]        = tx_busy;
    stat[STAT_TX_CNT +: 8]    = 8'(tx_count);
    stat[STAT_RX_CNT +: 8]    = 8'(rx_count);
  end

  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      case (reg_off)
        OFF_RXD:  rdata = 32'(rx_head);
        OFF_CON:  rdata = 32'(con_q);
        OFF_STAT: rdata = stat;
        OFF_DIV:  rdata = 32'(div_q);
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Self-checking bench for uart_mmio_fifo: register table, directed serial
// frames and randomized TX/RX traffic against queue-based models.
module tb_uart_mmio_fifo;

  localparam logic [31:0] BASE  = 32'h4000_0018;
  localparam int          DEPTH = 16;
  localparam logic [31:0] R_TXD = 32'h00, R_RXD = 32'h04, R_CON = 32'h08;
  localparam logic [31:0] R_STAT = 32'h0C, R_DIV = 32'h10;

  logic        clk = 1'b0, reset = 1'b0, rd = 1'b0, wr = 1'b0, uart_rx = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        uart_tx, irq;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  uart_mmio_fifo #(
    .BASE_ADDR (BASE),
    .DATA_W    (8),
    .FIFO_DEPTH(DEPTH),
    .DIV_W     (16),
    .DIV_RESET (325)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .irq    (irq)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] off, input logic [31:0] data);
    @(negedge clk);
    addr = BASE + off; wdata = data; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] off, output logic [31:0] data);
    @(negedge clk);
    addr = BASE + off; rd = 1'b1;
    #1 data = rdata;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Drive one serial character; the line is left at the stop value.
  task automatic send_char(input logic [7:0] b, input logic stop_v, input int div);
    int bt = 16 * div;
    uart_rx = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (bt) @(negedge clk);
    end
    uart_rx = stop_v;
    repeat (bt) @(negedge clk);
  endtask

  // Wait for a start bit and sample the frame at mid-bit; ends at mid-stop.
  task automatic tx_frame(input int div, output logic [7:0] b);
    int bt = 16 * div;
    int waited = 0;
    b = '0;
    while (uart_tx !== 1'b0 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (uart_tx !== 1'b0) begin
      check("tx_start_timeout", {31'b0, uart_tx}, 32'h0);
      return;
    end
    repeat (bt / 2) @(negedge clk);
    check("tx_start_bit", {31'b0, uart_tx}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      repeat (bt) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (bt) @(negedge clk);
    check("tx_stop_bit", {31'b0, uart_tx}, 32'h1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [13];
  logic [7:0]  txq [$];
  logic [7:0]  rxq [$];
  logic [31:0] v;
  logic [7:0]  b, a5;
  int          low, dv, eff, n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected $finish before it");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, R_CON,          32'h0,          32'h3};
    vecs[1]  = '{1'b0, R_STAT,         32'h0,          32'h2};
    vecs[2]  = '{1'b0, R_DIV,          32'h0,          32'd325};
    vecs[3]  = '{1'b0, R_RXD,          32'h0,          32'h0};
    vecs[4]  = '{1'b0, R_TXD,          32'h0,          32'h0};
    vecs[5]  = '{1'b1, R_DIV,          32'h0000_1234,  32'h0};
    vecs[6]  = '{1'b0, R_DIV,          32'h0,          32'h1234};
    vecs[7]  = '{1'b1, R_DIV,          32'hABCD_0007,  32'h0};
    vecs[8]  = '{1'b0, R_DIV,          32'h0,          32'h7};
    vecs[9]  = '{1'b1, R_CON,          32'hFFFF_FFF5,  32'h0};
    vecs[10] = '{1'b0, R_CON,          32'h0,          32'h5};
    vecs[11] = '{1'b0, 32'h14,         32'h0,          32'h0};
    vecs[12] = '{1'b0, 32'hFFFF_FFF8,  32'h0,          32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check("tx_in_reset", {31'b0, uart_tx}, 32'h1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("irq_after_reset", {31'b0, irq}, 32'h0);
    check("tx_after_reset", {31'b0, uart_tx}, 32'h1);
    addr = BASE + R_CON; rd = 1'b0;
    #1 check("rdata_no_rd", rdata, 32'h0);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_wr) bus_wr(vecs[i].off, vecs[i].data);
      else begin
        bus_rd(vecs[i].off, v);
        check($sformatf("vec%0d", i), v, vecs[i].exp);
      end
    end
    bus_wr(R_CON, 32'h3);

    // TX frame 0xA5 at DIV=1
    a5 = 8'hA5;
    bus_wr(R_DIV, 32'd1);
    bus_wr(R_TXD, 32'h0000_00A5);
    low = 0;
    while (uart_tx !== 1'b0 && low < 100) begin @(negedge clk); low++; end
    low = 0;
    while (uart_tx === 1'b0 && low < 100) begin @(negedge clk); low++; end
    check("a5_start_len", low, 32'd16);
    repeat (7) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a5_bit%0d", i), {31'b0, uart_tx}, {31'b0, a5[i]});
      if (i == 3) begin
        repeat (14) @(negedge clk);
        bus_rd(R_STAT, v);
        check("a5_busy", (v >> 7) & 32'h1, 32'h1);
        check("a5_tx_empty", (v >> 1) & 32'h1, 32'h1);
      end else begin
        repeat (16) @(negedge clk);
      end
    end
    check("a5_stop", {31'b0, uart_tx}, 32'h1);
    repeat (16) @(negedge clk);
    bus_rd(R_STAT, v);
    check("a5_stat_idle", v, 32'h2);

    // TX overflow with transmitter off, then drain and compare
    bus_wr(R_CON, 32'h2);
    txq.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (txq.size() < DEPTH) txq.push_back(b);
      bus_wr(R_TXD, {24'h0, b});
    end
    bus_rd(R_STAT, v);
    check("tx_ovf_stat", v, 32'h0000_1021);
    bus_wr(R_STAT, 32'h0);
    bus_rd(R_STAT, v);
    check("stat_wr_zero", v, 32'h0000_1021);
    bus_wr(R_STAT, 32'h20);
    bus_rd(R_STAT, v);
    check("tx_ovf_clear", v, 32'h0000_1001);
    bus_wr(R_CON, 32'h3);
    bus_rd(R_STAT, v);
    check("tx_busy_drain", (v >> 7) & 32'h1, 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      tx_frame(1, b);
      check($sformatf("tx_drain%0d", i), {24'h0, b}, {24'h0, txq.pop_front()});
    end

    // Random divisor batches; DIV=0 runs like DIV=1
    for (int k = 0; k < 2; k++) begin
      dv  = (k == 0) ? 0 : int'($urandom_range(2, 3));
      eff = (dv == 0) ? 1 : dv;
      bus_wr(R_DIV, dv);
      for (int i = 0; i < 3; i++) begin
        b = 8'($urandom);
        txq.push_back(b);
        bus_wr(R_TXD, {24'h0, b});
      end
      for (int i = 0; i < 3; i++) begin
        tx_frame(eff, b);
        check($sformatf("tx_div%0d_%0d", dv, i), {24'h0, b}, {24'h0, txq.pop_front()});
      end
    end
    repeat (60) @(negedge clk);

    // TX-empty interrupt
    bus_wr(R_CON, 32'hB);
    repeat (2) @(negedge clk);
    check("irq_tx_empty", {31'b0, irq}, 32'h1);
    bus_wr(R_CON, 32'h3);
    repeat (2) @(negedge clk);
    check("irq_tx_masked", {31'b0, irq}, 32'h0);

    // Single RX character with interrupt
    bus_wr(R_DIV, 32'd1);
    bus_wr(R_CON, 32'h7);
    send_char(8'h3C, 1'b1, 1);
    repeat (4) @(negedge clk);
    bus_rd(R_STAT, v);
    check("rx1_stat", v, 32'h0001_000A);
    check("rx1_irq", {31'b0, irq}, 32'h1);
    bus_rd(R_RXD, v);
    check("rx1_data", v, 32'h3C);
    bus_rd(R_STAT, v);
    check("rx1_stat_after", v, 32'h2);
    check("rx1_irq_after", {31'b0, irq}, 32'h0);

    // RX overrun: 17 characters without reading
    rxq.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (rxq.size() < DEPTH) rxq.push_back(b);
      send_char(b, 1'b1, 1);
    end
    repeat (4) @(negedge clk);
    bus_rd(R_STAT, v);
    check("rx_ovr_stat", v, 32'h0010_001E);
    for (int i = 0; i < DEPTH; i++) begin
      bus_rd(R_RXD, v);
      check($sformatf("rx_fifo%0d", i), v, {24'h0, rxq.pop_front()});
    end
    bus_rd(R_STAT, v);
    check("rx_drained", v, 32'h12);

    // Short low glitch must not produce a character
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    bus_rd(R_STAT, v);
    check("glitch_no_push", v, 32'h12);
    bus_wr(R_STAT, 32'h10);
    bus_rd(R_STAT, v);
    check("rx_ovr_clear", v, 32'h2);

    // Random RX at slower divisors
    for (int k = 0; k < 2; k++) begin
      dv = int'($urandom_range(2, 3));
      bus_wr(R_DIV, dv);
      n = 3;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        rxq.push_back(b);
        send_char(b, 1'b1, dv);
      end
      repeat (8) @(negedge clk);
      for (int i = 0; i < n; i++) begin
        bus_rd(R_RXD, v);
        check($sformatf("rx_div%0d_%0d", dv, i), v, {24'h0, rxq.pop_front()});
      end
    end

    // Frame error, break, then recovery
    bus_wr(R_DIV, 32'd1);
    send_char(8'h81, 1'b0, 1);
    repeat (64) @(negedge clk);
    bus_rd(R_STAT, v);
    check("frame_err_stat", v, 32'h42);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    send_char(8'h5A, 1'b1, 1);
    repeat (4) @(negedge clk);
    bus_rd(R_STAT, v);
    check("after_break_stat", v, 32'h0001_004A);
    bus_rd(R_RXD, v);
    check("after_break_data", v, 32'h5A);
    bus_wr(R_STAT, 32'h40);
    bus_rd(R_STAT, v);
    check("frame_err_clear", v, 32'h2);

    // Reset mid-frame
    bus_wr(R_CON, 32'h3);
    for (int i = 0; i < 3; i++) bus_wr(R_TXD, 32'h00);
    low = 0;
    while (uart_tx !== 1'b0 && low < 200) begin @(negedge clk); low++; end
    check("pre_reset_tx_low", {31'b0, uart_tx}, 32'h0);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1 check("reset_tx_high", {31'b0, uart_tx}, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus_rd(R_STAT, v);
    check("reset_stat", v, 32'h2);
    bus_rd(R_DIV, v);
    check("reset_div", v, 32'd325);
    bus_rd(R_CON, v);
    check("reset_con", v, 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
